// File: rtl/regfile_scoreboard.sv
// Integer register file with write-through bypass and per-register
// pending-write scoreboard for RAW hazard detection at decode.
module regfile_scoreboard #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int NUM_RD = 2,
  parameter int BYPASS = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_RD*$clog2(NREG)-1:0] rd_addr,
  output logic [NUM_RD*XLEN-1:0]       rd_data,
  output logic [NUM_RD-1:0]            rd_busy,
  input  logic                         we,
  input  logic [$clog2(NREG)-1:0]      wr_addr,
  input  logic [XLEN-1:0]              wr_data,
  input  logic                         issue_valid,
  input  logic [$clog2(NREG)-1:0]      issue_rd,
  output logic                         issue_stall,
  input  logic                         flush,
  output logic [$clog2(NREG):0]        busy_count
);

  localparam int AW = $clog2(NREG);

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] pending;
  logic [NREG-1:0] pend_nxt;
  logic [AW:0]     cnt;
  logic            wr_ok;
  logic            iss_ok;

  assign wr_ok  = we && (wr_addr != '0);
  assign issue_stall = issue_valid && (issue_rd != '0) &&
                       pending[issue_rd] &&
                       !(we && (wr_addr == issue_rd));
  assign iss_ok = issue_valid && !issue_stall &&
                  (issue_rd != '0) && !flush;

  // Read ports: x0 reads zero, optional forwarding of same-cycle write.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      if (rd_addr[k*AW +: AW] != '0) begin
        rd_data[k*XLEN +: XLEN] = regs[rd_addr[k*AW +: AW]];
        rd_busy[k] = pending[rd_addr[k*AW +: AW]];
        if ((BYPASS != 0) && wr_ok &&
            (wr_addr == rd_addr[k*AW +: AW])) begin
          rd_data[k*XLEN +: XLEN] = wr_data;
          rd_busy[k] = 1'b0;
        end
      end
    end
  end

  // Next pending vector: write clears, issue sets (issue wins), flush clears all.
  always_comb begin
    pend_nxt = pending;
    if (wr_ok) pend_nxt[wr_addr] = 1'b0;
    if (flush) pend_nxt = '0;
    else if (iss_ok) pend_nxt[issue_rd] = 1'b1;
    pend_nxt[0] = 1'b0;
  end

  // Population count of the next pending vector.
  always_comb begin
    cnt = '0;
    for (int i = 0; i < NREG; i++)
      cnt = cnt + {{AW{1'b0}}, pend_nxt[i]};
  end

  // State update: register data, pending bits and registered count.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      pending    <= '0;
      busy_count <= '0;
    end else begin
      if (wr_ok) regs[wr_addr] <= wr_data;
      pending    <= pend_nxt;
      busy_count <= cnt;
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard; a second instance is built
// with forwarding disabled and shares all inputs with the first.
module tb_regfile_scoreboard;

  logic        clk;
  logic        rst;
  logic [9:0]  rd_addr;
  logic        we;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        flush;

  logic [63:0] rd_data, nb_rd_data;
  logic [1:0]  rd_busy, nb_rd_busy;
  logic        issue_stall, nb_issue_stall;
  logic [5:0]  busy_count, nb_busy_count;

  int checks = 0;
  int errors = 0;

  regfile_scoreboard #(.BYPASS(1)) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_busy(rd_busy), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_stall(issue_stall), .flush(flush), .busy_count(busy_count)
  );

  regfile_scoreboard #(.BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(nb_rd_data),
    .rd_busy(nb_rd_busy), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_stall(nb_issue_stall), .flush(flush),
    .busy_count(nb_busy_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    we = 0; issue_valid = 0; flush = 0; rst = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    tick();
    rst = 0;
    for (int a = 0; a < 32; a++) begin
      rd_addr = {a[4:0], a[4:0]};
      #1;
      checks++;
      if (rd_data !== 64'h0 || nb_rd_data !== 64'h0) begin
        errors++;
        $display("FAIL reset_data a=%0d got %h/%h exp 0", a, rd_data, nb_rd_data);
      end
      checks++;
      if (rd_busy !== 2'b00 || nb_rd_busy !== 2'b00) begin
        errors++;
        $display("FAIL reset_busy a=%0d got %b/%b exp 00", a, rd_busy, nb_rd_busy);
      end
    end
    checks++;
    if (busy_count !== 6'd0 || nb_busy_count !== 6'd0) begin
      errors++;
      $display("FAIL reset_count got %0d/%0d exp 0", busy_count, nb_busy_count);
    end
  endtask

  task automatic test_write_read();
    we = 1; wr_addr = 5; wr_data = 32'hDEADBEEF;
    tick();
    wr_addr = 0; wr_data = 32'h12345678;
    tick();
    idle();
    rd_addr = {5'd5, 5'd5};
    #1;
    checks++;
    if (rd_data !== {2{32'hDEADBEEF}}) begin
      errors++;
      $display("FAIL wr_r5 got %h exp %h", rd_data, {2{32'hDEADBEEF}});
    end
    checks++;
    if (nb_rd_data !== {2{32'hDEADBEEF}}) begin
      errors++;
      $display("FAIL wr_r5_nb got %h exp %h", nb_rd_data, {2{32'hDEADBEEF}});
    end
    rd_addr = {5'd0, 5'd0};
    #1;
    checks++;
    if (rd_data !== 64'h0 || nb_rd_data !== 64'h0) begin
      errors++;
      $display("FAIL wr_r0 got %h/%h exp 0", rd_data, nb_rd_data);
    end
  endtask

  task automatic test_bypass();
    we = 1; wr_addr = 7; wr_data = 32'hA5A5A5A5;
    rd_addr = {5'd7, 5'd5};
    #1;
    checks++;
    if (rd_data[63:32] !== 32'hA5A5A5A5) begin
      errors++;
      $display("FAIL byp_fwd got %h exp a5a5a5a5", rd_data[63:32]);
    end
    checks++;
    if (nb_rd_data[63:32] !== 32'h0) begin
      errors++;
      $display("FAIL byp_nofwd got %h exp 0", nb_rd_data[63:32]);
    end
    checks++;
    if (rd_data[31:0] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL byp_port0 got %h exp deadbeef", rd_data[31:0]);
    end
    tick();
    idle();
    #1;
    checks++;
    if (nb_rd_data[63:32] !== 32'hA5A5A5A5) begin
      errors++;
      $display("FAIL byp_nb_later got %h exp a5a5a5a5", nb_rd_data[63:32]);
    end
  endtask

  task automatic test_scoreboard();
    issue_valid = 1; issue_rd = 3; rd_addr = {5'd0, 5'd3};
    #1;
    checks++;
    if (issue_stall !== 1'b0) begin
      errors++;
      $display("FAIL sb_first_stall got %b exp 0", issue_stall);
    end
    tick();
    issue_valid = 0;
    #1;
    checks++;
    if (rd_busy[0] !== 1'b1 || nb_rd_busy[0] !== 1'b1) begin
      errors++;
      $display("FAIL sb_busy got %b/%b exp 1", rd_busy[0], nb_rd_busy[0]);
    end
    checks++;
    if (busy_count !== 6'd1) begin
      errors++;
      $display("FAIL sb_count1 got %0d exp 1", busy_count);
    end
    issue_valid = 1; issue_rd = 3;
    #1;
    checks++;
    if (issue_stall !== 1'b1) begin
      errors++;
      $display("FAIL sb_restall got %b exp 1", issue_stall);
    end
    issue_rd = 0;
    #1;
    checks++;
    if (issue_stall !== 1'b0) begin
      errors++;
      $display("FAIL sb_x0_stall got %b exp 0", issue_stall);
    end
    tick();
    issue_valid = 0;
    #1;
    checks++;
    if (busy_count !== 6'd1) begin
      errors++;
      $display("FAIL sb_x0_count got %0d exp 1", busy_count);
    end
    we = 1; wr_addr = 3; wr_data = 32'h33;
    #1;
    checks++;
    if (rd_busy[0] !== 1'b0 || rd_data[31:0] !== 32'h33) begin
      errors++;
      $display("FAIL sb_wb_byp got %b %h exp 0 33", rd_busy[0], rd_data[31:0]);
    end
    checks++;
    if (nb_rd_busy[0] !== 1'b1) begin
      errors++;
      $display("FAIL sb_wb_nb got %b exp 1", nb_rd_busy[0]);
    end
    tick();
    idle();
    issue_valid = 1; issue_rd = 3;
    #1;
    checks++;
    if (busy_count !== 6'd0 || nb_rd_busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL sb_clear got %0d %b exp 0 0", busy_count, nb_rd_busy[0]);
    end
    checks++;
    if (issue_stall !== 1'b0) begin
      errors++;
      $display("FAIL sb_stall_drop got %b exp 0", issue_stall);
    end
    issue_valid = 0;
  endtask

  task automatic test_simul();
    issue_valid = 1; issue_rd = 9;
    tick();
    we = 1; wr_addr = 9; wr_data = 32'h99;
    rd_addr = {5'd0, 5'd9};
    #1;
    checks++;
    if (issue_stall !== 1'b0) begin
      errors++;
      $display("FAIL sim_stall got %b exp 0", issue_stall);
    end
    tick();
    idle();
    #1;
    checks++;
    if (rd_data[31:0] !== 32'h99 || rd_busy[0] !== 1'b1) begin
      errors++;
      $display("FAIL sim_state got %h %b exp 99 1", rd_data[31:0], rd_busy[0]);
    end
    checks++;
    if (busy_count !== 6'd1) begin
      errors++;
      $display("FAIL sim_count got %0d exp 1", busy_count);
    end
    we = 1; wr_addr = 9; wr_data = 32'h9A;
    tick();
    idle();
    #1;
    checks++;
    if (busy_count !== 6'd0) begin
      errors++;
      $display("FAIL sim_clear got %0d exp 0", busy_count);
    end
  endtask

  task automatic test_flush();
    issue_valid = 1;
    issue_rd = 1; tick();
    issue_rd = 2; tick();
    issue_rd = 4; tick();
    issue_valid = 0;
    #1;
    checks++;
    if (busy_count !== 6'd3) begin
      errors++;
      $display("FAIL fl_pre got %0d exp 3", busy_count);
    end
    flush = 1; issue_valid = 1; issue_rd = 6;
    we = 1; wr_addr = 2; wr_data = 32'h55;
    tick();
    idle();
    rd_addr = {5'd2, 5'd6};
    #1;
    checks++;
    if (busy_count !== 6'd0 || nb_busy_count !== 6'd0) begin
      errors++;
      $display("FAIL fl_count got %0d/%0d exp 0", busy_count, nb_busy_count);
    end
    checks++;
    if (rd_busy !== 2'b00) begin
      errors++;
      $display("FAIL fl_busy got %b exp 00", rd_busy);
    end
    checks++;
    if (rd_data[63:32] !== 32'h55 || nb_rd_data[63:32] !== 32'h55) begin
      errors++;
      $display("FAIL fl_data got %h/%h exp 55", rd_data[63:32], nb_rd_data[63:32]);
    end
  endtask

  task automatic test_reset_mid();
    issue_valid = 1; issue_rd = 10;
    we = 1; wr_addr = 11; wr_data = 32'h77;
    tick();
    rst = 1; issue_rd = 13; wr_addr = 12; wr_data = 32'hFF; flush = 0;
    tick();
    idle();
    rd_addr = {5'd12, 5'd11};
    #1;
    checks++;
    if (rd_data !== 64'h0 || nb_rd_data !== 64'h0) begin
      errors++;
      $display("FAIL rm_data got %h/%h exp 0", rd_data, nb_rd_data);
    end
    rd_addr = {5'd13, 5'd10};
    #1;
    checks++;
    if (rd_busy !== 2'b00 || busy_count !== 6'd0) begin
      errors++;
      $display("FAIL rm_pend got %b %0d exp 00 0", rd_busy, busy_count);
    end
    rd_addr = {5'd5, 5'd7};
    #1;
    checks++;
    if (rd_data !== 64'h0) begin
      errors++;
      $display("FAIL rm_old got %h exp 0", rd_data);
    end
  endtask

  initial begin
    rst = 1; we = 0; wr_addr = 0; wr_data = 0;
    issue_valid = 0; issue_rd = 0; flush = 0; rd_addr = 0;
    @(negedge clk);
    test_reset();
    test_write_read();
    test_bypass();
    test_scoreboard();
    test_simul();
    test_flush();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Parametrised integer register file with configurable width, depth and read-port count, plus write-through bypass and a per-register pending-write scoreboard. Sits in the decode/writeback path of the core: decode reads operands and marks its destination pending on issue; writeback writes the result and clears the pending bit, so decode can detect RAW hazards without a separate hazard unit.

## Interface
- XLEN, 32, data width of every register
- NREG, 32, number of registers; power of two, >= 2; register 0 is hard-wired zero
- NUM_RD, 2, number of independent read ports, >= 1
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = no forwarding
- AW (localparam), clog2(NREG), register address width

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- rd_addr  in  NUM_RD*AW  read addresses, port k at bits [k*AW +: AW]
- rd_data  out  NUM_RD*XLEN  read data, port k at bits [k*XLEN +: XLEN], combinational
- rd_busy  out  NUM_RD  port k source register has an outstanding write, combinational
- we  in  1  write enable
- wr_addr  in  AW  write address
- wr_data  in  XLEN  write data
- issue_valid  in  1  request to mark issue_rd pending
- issue_rd  in  AW  destination register being issued
- issue_stall  out  1  issue_rd already pending; request not accepted, combinational
- flush  in  1  clear all pending bits (pipeline flush)
- busy_count  out  AW+1  number of registers currently pending, registered

## Operation
- Storage: NREG x XLEN array plus NREG pending bits; register 0 has neither (reads 0, never pending).
- Read port k: rd_data = regs[rd_addr_k]; if rd_addr_k == 0, rd_data = 0 and rd_busy = 0.
- Bypass (BYPASS=1): if we && wr_addr != 0 && wr_addr == rd_addr_k, rd_data_k = wr_data and rd_busy_k = 0. BYPASS=0: stored value and stored pending bit returned.
- Write: we && wr_addr != 0 -> regs[wr_addr] <= wr_data; pending[wr_addr] <= 0. Writes to 0 discarded.
- Issue: issue_stall = issue_valid && issue_rd != 0 && pending[issue_rd] && !(we && wr_addr == issue_rd). Accepted when issue_valid && !issue_stall && issue_rd != 0 && !flush -> pending[issue_rd] <= 1. issue_rd == 0 accepted, no state change.
- Same-cycle write and accepted issue to the same register: data written, pending ends set (issue wins).
- Flush: all pending bits <= 0 next edge; issue ignored that cycle; a concurrent write still updates data.
- busy_count <= popcount of next-state pending vector; always equals popcount of pending after each edge.
- Reset: all registers 0, all pending 0, busy_count 0. Reset overrides we, issue, flush in the same cycle.

## Timing
- Read and rd_busy: zero latency (combinational from rd_addr, stored state and, with BYPASS=1, we/wr_addr/wr_data).
- Write: stored value visible on next cycle without bypass; same cycle with BYPASS=1.
- Issue: pending visible on rd_busy the cycle after acceptance.
- Writeback clears pending at the edge; rd_busy low same cycle when BYPASS=1, next cycle when BYPASS=0.
- issue_stall combinational; issuer holds issue_valid/issue_rd until the stall drops.
- busy_count updates one cycle after the causing issue/write/flush.
- Reset mid-operation: at the edge where rst = 1 all state is cleared; outputs reflect cleared state in the following cycle.
- No multicycle paths; all inputs sampled at rising clk only.

## Test plan
- Reset then read all: rst=1 for 1 cycle; sweep rd_addr 0..NREG-1 on every port -> rd_data = 0, rd_busy = 0, busy_count = 0.
- Write/read plus x0: write 0xDEADBEEF to r5, 0x12345678 to r0 -> next cycle r5 reads 0xDEADBEEF on all ports, r0 reads 0.
- Bypass: BYPASS=1, we=1 wr_addr=7 wr_data=0xA5A5A5A5, rd_addr port 1 = 7 in the same cycle -> rd_data1 = 0xA5A5A5A5; BYPASS=0 build -> old value 0.
- Scoreboard: issue r3 -> next cycle rd_busy=1 on port reading r3, busy_count=1; re-issue r3 -> issue_stall=1; write r3 -> pending cleared, busy_count=0, stall drops.
- Simultaneous write+issue r9: we=1 wr_addr=9 with issue_rd=9 -> issue_stall=0, data updated, r9 pending next cycle, busy_count=1.
- Flush/reset priority: pend r1,r2,r4 (busy_count=3); flush with issue r6 and write r2=0x55 -> busy_count=0, r6 not pending, r2 reads 0x55; rst during activity -> all zero next cycle.
